// File: rtl/mem_block_arbiter.sv
// Shares one 256-bit block-memory port between the I-refill and D-refill/writeback paths, round-robin on contention.
// Latency: grant one edge after request, strobe for LATENCY cycles, one-cycle done, then one idle cycle (LATENCY+2 per transaction).
// Backpressure: requests are level-held; a requester waits (worst case one foreign transaction) until its done pulse.
//
// Ports:
//   CLOCK, RESET                         : clock, synchronous active-high reset
//   IReq_IN/IAddr_IN -> IDone_OUT/IBlock_OUT   : instruction block read
//   DRead_IN/DWrite_IN/DAddr_IN/DBlock_IN -> DDone_OUT/DBlock_OUT : data block read/write
//   MemAddress_OUT, MemBlockRead_OUT, MemBlockWrite_OUT, MemBlock_OUT, MemBlock_IN : block memory port
//   Busy_OUT                             : high whenever a transaction (incl. its done cycle) is in flight
module mem_block_arbiter #(
  parameter int LATENCY = 10,
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               IReq_IN,
  input  logic [ADDR_W-1:0]  IAddr_IN,
  output logic               IDone_OUT,
  output logic [BLOCK_W-1:0] IBlock_OUT,
  input  logic               DRead_IN,
  input  logic               DWrite_IN,
  input  logic [ADDR_W-1:0]  DAddr_IN,
  input  logic [BLOCK_W-1:0] DBlock_IN,
  output logic               DDone_OUT,
  output logic [BLOCK_W-1:0] DBlock_OUT,
  output logic [ADDR_W-1:0]  MemAddress_OUT,
  output logic               MemBlockRead_OUT,
  output logic               MemBlockWrite_OUT,
  output logic [BLOCK_W-1:0] MemBlock_OUT,
  input  logic [BLOCK_W-1:0] MemBlock_IN,
  output logic               Busy_OUT
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_grant_q, last_grant_d;  // 1 = data side, 0 = instruction side
  logic                 op_wr_q, op_wr_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   wblk_q, wblk_d;
  logic [BLOCK_W-1:0]   iblk_q, iblk_d;
  logic [BLOCK_W-1:0]   dblk_q, dblk_d;

  logic                 d_req;
  logic                 grant_d_side;

  assign d_req = DRead_IN | DWrite_IN;
  // On contention the side that did not win last time gets the port.
  assign grant_d_side = d_req & (~IReq_IN | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wblk_d       = wblk_q;
    iblk_d       = iblk_q;
    dblk_d       = dblk_q;
    case (state_q)
      IDLE: begin
        if (IReq_IN || d_req) begin
          cnt_d        = LAT_M1;
          last_grant_d = grant_d_side;
          if (grant_d_side) begin
            state_d = DBUSY;
            addr_d  = DAddr_IN;
            // Write wins when both read and write are requested.
            op_wr_d = DWrite_IN;
            rd_d    = ~DWrite_IN;
            wr_d    = DWrite_IN;
            if (DWrite_IN) begin
              wblk_d = DBlock_IN;
            end
          end else begin
            state_d = IBUSY;
            addr_d  = IAddr_IN;
            op_wr_d = 1'b0;
            rd_d    = 1'b1;
            wr_d    = 1'b0;
          end
        end
      end
      IBUSY, DBUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (!op_wr_q) begin
            if (state_q == IBUSY) begin
              iblk_d = MemBlock_IN;
            end else begin
              dblk_d = MemBlock_IN;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // Always drop through IDLE so the just-served requester can release its request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b0;
      op_wr_q      <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wblk_q       <= '0;
      iblk_q       <= '0;
      dblk_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wblk_q       <= wblk_d;
      iblk_q       <= iblk_d;
      dblk_q       <= dblk_d;
    end
  end

  // last_grant_q still names the side being served while in DONE.
  assign IDone_OUT         = (state_q == DONE) & ~last_grant_q;
  assign DDone_OUT         = (state_q == DONE) &  last_grant_q;
  assign IBlock_OUT        = iblk_q;
  assign DBlock_OUT        = dblk_q;
  assign MemAddress_OUT    = addr_q;
  assign MemBlockRead_OUT  = rd_q;
  assign MemBlockWrite_OUT = wr_q;
  assign MemBlock_OUT      = wblk_q;
  assign Busy_OUT          = (state_q != IDLE);

endmodule
